parking_gate_ctrl: RTL and testbench

PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

---
 rtl/parking_pkg.sv | 19 +
 rtl/sync_edge.sv | 25 ++
 rtl/parking_gate_ctrl.sv | 154 +++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate controller.
package parking_pkg;
   localparam int NUM_SLOTS = 3;
   localparam int TIME_W    = 10;

   localparam logic [NUM_SLOTS-1:0] SLOT1 = 3'b001;
   localparam logic [NUM_SLOTS-1:0] SLOT2 = 3'b010;
   localparam logic [NUM_SLOTS-1:0] SLOT3 = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OPEN   = 2'd1,
      ST_REJECT = 2'd2
   } gate_state_e;

   function automatic logic is_onehot(input logic [NUM_SLOTS-1:0] v);
      return (v == SLOT1) || (v == SLOT2) || (v == SLOT3);
   endfunction
endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for a raw push-button followed by a rising-edge detector.
module sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic rise_o
);
   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rise_o = sync_q & ~prev_q;
endmodule

// File: rtl/parking_gate_ctrl.sv
// Three-slot parking barrier: validates entry/exit requests, tracks occupancy,
// holds the gate or error indicator for a fixed time and runs the billing time base.
//
// state     | meaning
// ST_IDLE   | waiting for a synchronized button edge
// ST_OPEN   | accepted event, gate_open held for GATE_CYCLES
// ST_REJECT | rejected request, err held for GATE_CYCLES
module parking_gate_ctrl
   import parking_pkg::*;
#(
   parameter int GATE_CYCLES = 50,
   parameter int TICK_DIV    = 1000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enter_btn,
   input  logic                 exit_btn,
   input  logic [NUM_SLOTS-1:0] slot_sw,
   output logic                 car_enter,
   output logic                 car_exit,
   output logic [NUM_SLOTS-1:0] car_sel,
   output logic [TIME_W-1:0]    timer_count,
   output logic [NUM_SLOTS-1:0] occupied,
   output logic [1:0]           free_cnt,
   output logic                 full,
   output logic                 gate_open,
   output logic                 err
);
   localparam logic [9:0]  HOLD_LOAD = 10'(GATE_CYCLES - 1);
   localparam logic [15:0] PRE_LAST  = 16'(TICK_DIV - 1);

   logic enter_rise;
   logic exit_rise;
   logic [NUM_SLOTS-1:0] slot_meta_q;
   logic [NUM_SLOTS-1:0] slot_sync_q;

   gate_state_e          state_q;
   logic [9:0]           hold_q;
   logic                 car_enter_q;
   logic                 car_exit_q;
   logic [NUM_SLOTS-1:0] car_sel_q;
   logic [NUM_SLOTS-1:0] occupied_q;
   logic                 gate_open_q;
   logic                 err_q;
   logic [15:0]          presc_q;
   logic [TIME_W-1:0]    timer_q;

   logic slot_ok;
   logic slot_taken;

   sync_edge u_enter_sync (
      .clk    (clk),
      .reset  (reset),
      .d_i    (enter_btn),
      .rise_o (enter_rise)
   );

   sync_edge u_exit_sync (
      .clk    (clk),
      .reset  (reset),
      .d_i    (exit_btn),
      .rise_o (exit_rise)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_meta_q <= '0;
         slot_sync_q <= '0;
      end else begin
         slot_meta_q <= slot_sw;
         slot_sync_q <= slot_meta_q;
      end
   end

   assign slot_ok    = is_onehot(slot_sync_q);
   assign slot_taken = |(occupied_q & slot_sync_q);

   // Enter is checked first so a simultaneous exit edge is simply lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         hold_q      <= '0;
         car_enter_q <= 1'b0;
         car_exit_q  <= 1'b0;
         car_sel_q   <= '0;
         occupied_q  <= '0;
         gate_open_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         car_enter_q <= 1'b0;
         car_exit_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               hold_q <= HOLD_LOAD;
               if (enter_rise) begin
                  if (slot_ok && !slot_taken) begin
                     car_enter_q <= 1'b1;
                     car_sel_q   <= slot_sync_q;
                     occupied_q  <= occupied_q | slot_sync_q;
                     gate_open_q <= 1'b1;
                     state_q     <= ST_OPEN;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= ST_REJECT;
                  end
               end else if (exit_rise) begin
                  if (slot_ok && slot_taken) begin
                     car_exit_q  <= 1'b1;
                     car_sel_q   <= slot_sync_q;
                     occupied_q  <= occupied_q & ~slot_sync_q;
                     gate_open_q <= 1'b1;
                     state_q     <= ST_OPEN;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= ST_REJECT;
                  end
               end
            end
            ST_OPEN, ST_REJECT: begin
               if (hold_q == '0) begin
                  gate_open_q <= 1'b0;
                  err_q       <= 1'b0;
                  state_q     <= ST_IDLE;
               end else begin
                  hold_q <= hold_q - 10'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q <= '0;
         timer_q <= '0;
      end else if (presc_q == PRE_LAST) begin
         presc_q <= '0;
         timer_q <= timer_q + 1'b1;
      end else begin
         presc_q <= presc_q + 16'd1;
      end
   end

   assign car_enter   = car_enter_q;
   assign car_exit    = car_exit_q;
   assign car_sel     = car_sel_q;
   assign occupied    = occupied_q;
   assign gate_open   = gate_open_q;
   assign err         = err_q;
   assign timer_count = timer_q;
   assign free_cnt    = 2'(NUM_SLOTS - $countones(occupied_q));
   assign full        = (occupied_q == 3'b111);
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: scoreboard of expected events plus per-scenario checks.
module tb_parking_gate_ctrl;
   import parking_pkg::*;

   localparam int GATE = 50;
   localparam int TICK = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enter_btn = 1'b0;
   logic       exit_btn = 1'b0;
   logic [2:0] slot_sw = 3'b000;
   logic       car_enter, car_exit, full, gate_open, err;
   logic [2:0] car_sel, occupied;
   logic [1:0] free_cnt;
   logic [9:0] timer_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         kind;
      logic [2:0] sel;
      logic [2:0] occ;
   } exp_t;

   exp_t       sb_q[$];
   logic [2:0] occ_m = 3'b000;
   logic [2:0] sel_m = 3'b000;

   exp_t mon_e;
   int   mon_kind;
   logic err_prev = 1'b0;

   parking_gate_ctrl #(.GATE_CYCLES(GATE), .TICK_DIV(TICK)) dut (
      .clk         (clk),
      .reset       (reset),
      .enter_btn   (enter_btn),
      .exit_btn    (exit_btn),
      .slot_sw     (slot_sw),
      .car_enter   (car_enter),
      .car_exit    (car_exit),
      .car_sel     (car_sel),
      .timer_count (timer_count),
      .occupied    (occupied),
      .free_cnt    (free_cnt),
      .full        (full),
      .gate_open   (gate_open),
      .err         (err)
   );

   always #5 clk = ~clk;

   // Event monitor: kind 1 = accepted entry, 2 = accepted exit, 3 = rejection.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            err_prev = 1'b0;
         end else begin
            if (car_enter || car_exit || (err && !err_prev)) begin
               mon_kind = car_enter ? 1 : (car_exit ? 2 : 3);
               checks++;
               if (sb_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_event: got kind=%0d sel=%b occ=%b, required none", mon_kind, car_sel, occupied);
               end else begin
                  mon_e = sb_q.pop_front();
                  if (mon_kind !== mon_e.kind || car_sel !== mon_e.sel || occupied !== mon_e.occ) begin
                     errors++;
                     $display("FAIL event: got kind=%0d sel=%b occ=%b, required kind=%0d sel=%b occ=%b",
                              mon_kind, car_sel, occupied, mon_e.kind, mon_e.sel, mon_e.occ);
                  end
               end
            end
            err_prev = err;
         end
      end
   end

   function automatic logic onehot3(input logic [2:0] v);
      return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
   endfunction

   task automatic run_request(input logic e, input logic x, input logic [2:0] slot,
                              input bit inject_drop, input string name);
      exp_t ex;
      logic acc;
      int   n;
      slot_sw = slot;
      repeat (3) @(negedge clk);
      if (e) acc = onehot3(slot) && ((occ_m & slot) == 3'b000);
      else   acc = onehot3(slot) && ((occ_m & slot) != 3'b000);
      if (acc) begin
         sel_m   = slot;
         occ_m   = e ? (occ_m | slot) : (occ_m & ~slot);
         ex.kind = e ? 1 : 2;
      end else begin
         ex.kind = 3;
      end
      ex.sel = sel_m;
      ex.occ = occ_m;
      sb_q.push_back(ex);
      enter_btn = e;
      exit_btn  = x;
      n = 0;
      while (!(gate_open || err) && n < 10) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== 3) begin
         errors++;
         $display("FAIL %s latency: got %0d cycles, required 3", name, n);
      end
      checks++;
      if (gate_open !== acc || err !== !acc) begin
         errors++;
         $display("FAIL %s indicator: got gate_open=%b err=%b, required gate_open=%b err=%b",
                  name, gate_open, err, acc, !acc);
      end
      enter_btn = 1'b0;
      exit_btn  = 1'b0;
      n = 1;
      while ((gate_open || err) && n < 200) begin
         @(negedge clk);
         if (inject_drop && n == 5) begin
            slot_sw   = SLOT2;
            enter_btn = 1'b1;
         end
         if (inject_drop && n == 12) enter_btn = 1'b0;
         if (gate_open || err) n++;
      end
      checks++;
      if (n !== GATE) begin
         errors++;
         $display("FAIL %s hold_length: got %0d cycles, required %0d", name, n, GATE);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_state(input string name, input logic [2:0] occ_exp, input logic [2:0] sel_exp);
      checks++;
      if (occupied !== occ_exp || car_sel !== sel_exp ||
          free_cnt !== 2'(3 - $countones(occ_exp)) || full !== (occ_exp == 3'b111)) begin
         errors++;
         $display("FAIL %s state: got occ=%b sel=%b free=%0d full=%b, required occ=%b sel=%b free=%0d full=%b",
                  name, occupied, car_sel, free_cnt, full, occ_exp, sel_exp,
                  3 - $countones(occ_exp), (occ_exp == 3'b111));
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (car_enter !== 1'b0 || car_exit !== 1'b0 || car_sel !== 3'b000 || timer_count !== 10'd0 ||
          occupied !== 3'b000 || free_cnt !== 2'd3 || full !== 1'b0 || gate_open !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: got enter=%b exit=%b sel=%b timer=%0d occ=%b free=%0d full=%b gate=%b err=%b, required all zero free=3",
                  car_enter, car_exit, car_sel, timer_count, occupied, free_cnt, full, gate_open, err);
      end
      reset = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (timer_count !== 10'd10) begin
         errors++;
         $display("FAIL timer_rate: got %0d, required 10", timer_count);
      end
   endtask

   task automatic test_enter_basic;
      run_request(1'b1, 1'b0, SLOT1, 1'b1, "enter_s1_drop");
      check_state("enter_s1", 3'b001, 3'b001);
   endtask

   task automatic test_exit_empty;
      run_request(1'b0, 1'b1, SLOT3, 1'b0, "exit_empty_s3");
      check_state("exit_empty_s3", 3'b001, 3'b001);
   endtask

   task automatic test_fill_full;
      run_request(1'b1, 1'b0, SLOT2, 1'b0, "enter_s2");
      run_request(1'b1, 1'b0, SLOT3, 1'b0, "enter_s3");
      check_state("filled", 3'b111, 3'b100);
      run_request(1'b1, 1'b0, SLOT2, 1'b0, "enter_full");
      check_state("enter_full", 3'b111, 3'b100);
   endtask

   task automatic test_exit_valid;
      run_request(1'b0, 1'b1, SLOT1, 1'b0, "exit_s1");
      check_state("exit_s1", 3'b110, 3'b001);
   endtask

   task automatic test_bad_slot;
      run_request(1'b1, 1'b0, 3'b011, 1'b0, "enter_011");
      check_state("enter_011", 3'b110, 3'b001);
   endtask

   task automatic test_simultaneous;
      run_request(1'b1, 1'b1, SLOT1, 1'b0, "enter_exit_same_edge");
      check_state("enter_exit_same_edge", 3'b111, 3'b001);
   endtask

   task automatic test_timer_wrap;
      logic [9:0] prev;
      int n;
      prev = timer_count;
      n = 0;
      while (!(prev != 10'd1023 && timer_count == 10'd1023) && n < 3000) begin
         prev = timer_count;
         @(negedge clk);
         n++;
      end
      checks++;
      if (timer_count !== 10'd1023) begin
         errors++;
         $display("FAIL timer_reach_1023: got %0d, required 1023", timer_count);
      end
      @(negedge clk);
      checks++;
      if (timer_count !== 10'd1023) begin
         errors++;
         $display("FAIL timer_hold_1023: got %0d, required 1023", timer_count);
      end
      @(negedge clk);
      checks++;
      if (timer_count !== 10'd0) begin
         errors++;
         $display("FAIL timer_wrap: got %0d, required 0", timer_count);
      end
   endtask

   task automatic test_reset_mid_open;
      exp_t ex;
      int   n;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      occ_m = 3'b000;
      sel_m = 3'b000;
      slot_sw = SLOT1;
      repeat (3) @(negedge clk);
      ex.kind = 1; ex.sel = SLOT1; ex.occ = SLOT1;
      sb_q.push_back(ex);
      enter_btn = 1'b1;
      n = 0;
      while (!gate_open && n < 10) begin
         @(negedge clk);
         n++;
      end
      repeat (10) @(negedge clk);
      slot_sw = SLOT2;
      reset = 1'b1;
      #1;
      checks++;
      if (gate_open !== 1'b0 || occupied !== 3'b000 || free_cnt !== 2'd3 || car_sel !== 3'b000) begin
         errors++;
         $display("FAIL reset_mid_open: got gate=%b occ=%b free=%0d sel=%b, required gate=0 occ=000 free=3 sel=000",
                  gate_open, occupied, free_cnt, car_sel);
      end
      repeat (3) @(negedge clk);
      ex.kind = 1; ex.sel = SLOT2; ex.occ = SLOT2;
      sb_q.push_back(ex);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (gate_open !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: got gate=%b err=%b, required 0 0", gate_open, err);
      end
      @(negedge clk);
      checks++;
      if (gate_open !== 1'b1 || occupied !== SLOT2) begin
         errors++;
         $display("FAIL held_button_through_reset: got gate=%b occ=%b, required gate=1 occ=010", gate_open, occupied);
      end
      n = 0;
      while (gate_open && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      enter_btn = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   initial begin
      test_reset;
      test_enter_basic;
      test_exit_empty;
      test_fill_full;
      test_exit_valid;
      test_bad_slot;
      test_simultaneous;
      test_timer_wrap;
      test_reset_mid_open;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending events, required 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
